// File: rtl/serial_sub32_if.sv
// serial_sub32_if: request/result bundle for the bit-serial subtractor.
//   start      - request from the control FSM, sampled only when the unit is idle or just finished
//   a, b       - minuend and subtrahend, captured on the accepting edge
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when diff/carryout/overflow are valid
//   diff       - a - b, held until the next accept
//   carryout   - final carry out of the MSB (1 means no borrow)
//   overflow   - signed overflow (carry into MSB XOR carry out of MSB)
// Modports: master drives the request side, slave is the subtractor.
interface serial_sub32_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, carryout, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, carryout, overflow
    );
endinterface

// File: rtl/serial_sub32.sv
// serial_sub32: bit-serial two's-complement subtractor, diff = a + ~b + 1,
// one full-adder cell with a registered carry, LSB first.
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; discards any operation in flight
//   bus    - serial_sub32_if.slave (start/a/b in, busy/done/diff/carryout/overflow out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, results held
// RUN   | one bit per edge through the adder cell, count = bit index
// DONE  | single cycle with done high; start here re-accepts at once
module serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    serial_sub32_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             carryout_q;
    logic             overflow_q;

    logic             cell_sum;
    logic             cell_cout;
    logic [WIDTH-1:0] sr_next;

    assign cell_sum  = sa[0] ^ sb[0] ^ carry;
    assign cell_cout = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 sits at sr[0].
    assign sr_next   = {cell_sum, sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            carry      <= 1'b0;
            count      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= ~bus.b;
                        carry  <= 1'b1;   // the +1 of the two's-complement negate
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sr    <= sr_next;
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    carry <= cell_cout;
                    count <= count + CW'(1);
                    if (count == LAST_BIT) begin
                        // carry still holds the carry into the MSB cell here
                        diff_q     <= sr_next;
                        carryout_q <= cell_cout;
                        overflow_q <= carry ^ cell_cout;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_sub32.sv
// tb_serial_sub32: self-checking bench for serial_sub32 with a plain-arithmetic reference model.
module tb_serial_sub32;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_sub32_if #(.WIDTH(WIDTH)) bus ();

    serial_sub32 #(.WIDTH(WIDTH), .CW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carryout, diff} from integer arithmetic.
    function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        longint    s;
        logic      ovf;
        logic      cout;
        logic [31:0] d;
        d    = a - b;
        cout = (a >= b);
        s    = longint'($signed(a)) - longint'($signed(b));
        ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {ovf, cout, d};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit disturb, input string tag);
        logic [33:0] r;
        int          lat;
        r   = ref_sub(a, b);
        lat = 0;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                check_val({tag, " busy"}, 64'(bus.busy), 64'd1);
            end
            if (disturb) begin
                if (i == 5) begin
                    bus.start = 1'b1;
                    bus.a     = 32'd100;
                    bus.b     = 32'd1;
                end else begin
                    bus.start = 1'b0;
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                end
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        check_val({tag, " latency"}, 64'(lat), 64'd33);
        check_val({tag, " diff"}, 64'(bus.diff), 64'(r[31:0]));
        check_val({tag, " carryout"}, 64'(bus.carryout), 64'(r[32]));
        check_val({tag, " overflow"}, 64'(bus.overflow), 64'(r[33]));
        @(negedge clk);
        check_val({tag, " done pulse"}, 64'(bus.done), 64'd0);
        check_val({tag, " diff held"}, 64'(bus.diff), 64'(r[31:0]));
    endtask

    initial begin
        int lat;
        bit seen;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #2 reset  = 1'b1;
        #1;
        check_val("reset busy", 64'(bus.busy), 64'd0);
        check_val("reset done", 64'(bus.done), 64'd0);
        check_val("reset diff", 64'(bus.diff), 64'd0);
        check_val("reset carryout", 64'(bus.carryout), 64'd0);
        check_val("reset overflow", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'h77777777, 32'hBBBBBBBB, 1'b0, "mixed sign");
        run_op(32'h00000005, 32'h00000005, 1'b0, "equal");
        run_op(32'h00000000, 32'h00000001, 1'b0, "zero minus one");
        run_op(32'h80000000, 32'h00000001, 1'b0, "min minus one");
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, "max minus neg1");
        run_op(32'd9, 32'd3, 1'b1, "start ignored in run");

        // Abort mid-operation with reset.
        bus.a     = 32'h12345678;
        bus.b     = 32'h00000001;
        bus.start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check_val("abort busy", 64'(bus.busy), 64'd0);
        check_val("abort done", 64'(bus.done), 64'd0);
        check_val("abort diff", 64'(bus.diff), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check_val("abort no done", 64'(seen), 64'd0);
        run_op(32'h00000064, 32'h00000001, 1'b0, "after abort");

        // Back-to-back with start held high, re-accepted in the DONE cycle.
        bus.a     = 32'd10;
        bus.b     = 32'd4;
        bus.start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.a = 32'd4;
                bus.b = 32'd10;
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check_val("b2b first latency", 64'(lat), 64'd33);
        check_val("b2b first diff", 64'(bus.diff), 64'd6);
        check_val("b2b first carryout", 64'(bus.carryout), 64'd1);
        check_val("b2b first overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check_val("b2b reaccept busy", 64'(bus.busy), 64'd1);
        check_val("b2b reaccept done", 64'(bus.done), 64'd0);
        lat = 0;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j + 1;
                break;
            end
        end
        check_val("b2b second latency", 64'(lat), 64'd33);
        check_val("b2b second diff", 64'(bus.diff), 64'hFFFFFFFA);
        check_val("b2b second carryout", 64'(bus.carryout), 64'd0);
        check_val("b2b second overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = (k % 5 == 0) ? ra : 32'($urandom);
            if (k % 7 == 3) ra[31] = ~rb[31];
            run_op(ra, rb, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_sub32.md
Name: serial_sub32

Overview:
- Bit-serial two's-complement subtractor. Computes diff = a - b as a + ~b + 1, one bit per clock, using a single full-adder cell with a registered carry.
- Complements the combinational 32-bit ripple adder. It gives the datapath a subtract path with low gate count, trading latency for area.
- Sits beside the ALU adder and is driven by a start/busy/done handshake from the control FSM.
- Flags follow the adder convention: carryout is the final carry (1 means no borrow); overflow is c[WIDTH] XOR c[WIDTH-1].

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 2.
- CW, 5, bit-counter width; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, two's complement; captured on the accepting edge
- b  input  WIDTH  subtrahend, two's complement; captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  a - b; held stable from done until the next accept
- carryout  output  1  final carry out of the MSB; 1 means a >= b unsigned
- overflow  output  1  signed overflow, carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, active-high; any time, including mid-operation):
  - state goes to IDLE.
  - busy, done, diff, carryout and overflow all go to 0.
  - Operand shift registers, counter and carry go to 0.
  - The in-flight operation is discarded and no done follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 is accepted. On that edge: load a into sa and ~b into sb, set carry=1, count=0, go to RUN, busy=1.
  - Outputs keep their prior values.
- RUN, each edge:
  - Full-add sa[0], sb[0] and carry.
  - Shift the sum bit into the MSB of the result shift register (LSB-first fill).
  - Shift sa and sb right by one.
  - carry <= carry-out of the cell.
  - count <= count + 1.
- On the RUN edge where count == WIDTH-1 (the MSB cell):
  - Latch overflow = cell carry-in XOR cell carry-out.
  - Latch carryout = cell carry-out.
  - Copy the completed result to diff.
  - busy=0, done=1, go to DONE.
- Latency: start is accepted at edge k. done is high for the cycle following edge k+WIDTH (32 cycles at default). Throughput is one operation per WIDTH+1 cycles when back-to-back.
- DONE lasts exactly one cycle:
  - start=1 re-accepts (same actions as IDLE) and goes to RUN, so done drops.
  - Otherwise go to IDLE with results held.
- start in RUN is ignored. Operands, counter and outputs are unaffected; the bench must not see an early done.
- a and b changing while busy has no effect, because only the captured copies are used.
- diff, carryout and overflow never show partial results; they update only on the completion edge.
- Counter must not wrap before completion. Completion is detected on count == WIDTH-1, not on counter overflow.
- All logic is synchronous to clk except reset. Gate-level cells may use the team's standard delay macros. Simulation must allow at least 10 time units of cell delay per bit within the clock period.

Test Plan:
- a=0x77777777, b=0xBBBBBBBB, start for 1 cycle -> done 32 cycles later; diff=0xBBBBBBBC, carryout=0, overflow=1.
- a=0x00000005, b=0x00000005 -> diff=0x00000000, carryout=1, overflow=0. Then a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, carryout=0, overflow=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, carryout=1, overflow=1. And a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, carryout=0, overflow=1.
- Accept a=9, b=3. Pulse start with a=100, b=1 at cycle 5 and change the a/b inputs while busy -> single done at cycle 32; diff=0x00000006, carryout=1, overflow=0.
- Accept an op, assert reset at cycle 10 for 1 cycle -> busy=0, done=0, diff=0 immediately. No done for 40 cycles. A fresh start afterwards completes normally.
- Back-to-back: start held high continuously with a=10, b=4 then a=4, b=10 -> done at cycle 32 with diff=6; re-accept in the DONE cycle; second done 33 cycles later with diff=0xFFFFFFFA, carryout=0, overflow=0.
